// File: rtl/psum_ofifo.sv
// Per-column partial-sum output FIFO: independent column writes, whole-row first-word-fall-through pops.
// Optional sticky o_overflow flag for dropped writes is enabled by defining PSUM_OFIFO_OVF_EN.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_valid,
`ifdef PSUM_OFIFO_OVF_EN
    output logic                     o_overflow,
`endif
    output logic [col*psum_bw-1:0]   out
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic                   pop;
    logic [col-1:0]         full_vec;
    logic [col-1:0]         avail_vec;
    logic [col*psum_bw-1:0] head;
`ifdef PSUM_OFIFO_OVF_EN
    logic [col-1:0]         drop_vec;
`endif

    // A row only leaves when every column has contributed its entry.
    assign pop = rd & o_valid;

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic [psum_bw-1:0] mem [depth];
            logic [AW-1:0]      wr_ptr_reg;
            logic [AW-1:0]      rd_ptr_reg;
            logic [CW-1:0]      count_reg;
            logic               push;

            assign full_vec[gi]  = (count_reg == CW'(depth));
            assign avail_vec[gi] = (count_reg != '0);
            // A full column still accepts a write when the same edge pops its head.
            assign push          = wr[gi] & (~full_vec[gi] | pop);
`ifdef PSUM_OFIFO_OVF_EN
            assign drop_vec[gi]  = wr[gi] & full_vec[gi] & ~pop;
`endif

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= in[gi*psum_bw +: psum_bw];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            assign head[gi*psum_bw +: psum_bw] = mem[rd_ptr_reg];
        end
    endgenerate

    assign o_valid = &avail_vec;
    assign o_full  = |full_vec;
    assign o_ready = ~o_full;
    // Storage is never reset, so the bus is masked until a complete row exists.
    assign out     = o_valid ? head : '0;

`ifdef PSUM_OFIFO_OVF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_overflow <= 1'b0;
        end else if (|drop_vec) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomised and directed bench for psum_ofifo, checked against a queue-per-column reference model.
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk;
    logic                reset;
    logic [COL*BW-1:0]   in_bus;
    logic [COL-1:0]      wr;
    logic                rd;
    logic                o_ready;
    logic                o_full;
    logic                o_valid;
    logic [COL*BW-1:0]   out_bus;
`ifdef PSUM_OFIFO_OVF_EN
    logic                o_overflow;
`endif

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_bus),
        .wr         (wr),
        .rd         (rd),
        .o_ready    (o_ready),
        .o_full     (o_full),
        .o_valid    (o_valid),
`ifdef PSUM_OFIFO_OVF_EN
        .o_overflow (o_overflow),
`endif
        .out        (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] mq [COL][$];
    logic          m_ovf;
    int            n_checks;
    int            n_fail;
    int            n_txn;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < COL; c++) mq[c].delete();
        m_ovf = 1'b0;
    endtask

    // Applies one clock edge of FIFO rules to the queues.
    task automatic model_edge(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        logic          valid;
        logic          do_pop;
        logic [COL-1:0] was_full;
        valid = 1'b1;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0) valid = 1'b0;
            was_full[c] = (mq[c].size() == DEPTH);
        end
        do_pop = r && valid;
        if (do_pop) for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
        for (int c = 0; c < COL; c++) begin
            if (w[c]) begin
                if (!was_full[c] || do_pop) mq[c].push_back(d[c*BW +: BW]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic              ev;
        logic              ef;
        logic [COL*BW-1:0] eo;
        ev = 1'b1;
        ef = 1'b0;
        eo = '0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == 0) ev = 1'b0;
            if (mq[c].size() == DEPTH) ef = 1'b1;
        end
        if (ev) for (int c = 0; c < COL; c++) eo[c*BW +: BW] = mq[c][0];
        check({tag, ".valid"}, 128'(o_valid), 128'(ev));
        check({tag, ".full"},  128'(o_full),  128'(ef));
        check({tag, ".ready"}, 128'(o_ready), 128'(!ef));
        check({tag, ".out"},   128'(out_bus), 128'(eo));
`ifdef PSUM_OFIFO_OVF_EN
        check({tag, ".ovf"},   128'(o_overflow), 128'(m_ovf));
`endif
    endtask

    task automatic step(input string tag, input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
        @(negedge clk);
        wr     = w;
        in_bus = d;
        rd     = r;
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        compare_outputs(tag);
        n_txn++;
        $display("txn %0d %s wr=%h rd=%b valid=%b full=%b out=%h", n_txn, tag, w, r, o_valid, o_full, out_bus);
    endtask

    function automatic logic [COL*BW-1:0] all_cols(input logic [BW-1:0] v);
        logic [COL*BW-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_row();
        logic [COL*BW-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Asserts reset mid-cycle and checks the outputs clear without waiting for an edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        wr    = '0;
        rd    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        compare_outputs({tag, ".imm"});
        @(posedge clk);
        #1;
        compare_outputs({tag, ".hold"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [COL*BW-1:0] exp_row;
        n_checks = 0;
        n_fail   = 0;
        n_txn    = 0;
        reset    = 1'b0;
        wr       = '0;
        rd       = 1'b0;
        in_bus   = '0;
        model_clear();
        #2;
        compare_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Skewed column arrival: row completes only on the eighth write.
        exp_row = '0;
        for (int c = 0; c < COL; c++) begin
            logic [COL*BW-1:0] d;
            d = '0;
            d[c*BW +: BW] = BW'(16'h0100 + c);
            exp_row[c*BW +: BW] = BW'(16'h0100 + c);
            step("skew", COL'(1) << c, d, 1'b0);
            check("skew.valid_rise", 128'(o_valid), 128'(c == COL - 1));
        end
        check("skew.row", 128'(out_bus), 128'(exp_row));
        step("skew_pop", '0, '0, 1'b1);

        // Fill to full, drop an extra write, drain in order.
        for (int k = 0; k < DEPTH; k++) step("fill", '1, all_cols(BW'(k)), 1'b0);
        check("fill.full", 128'(o_full), 128'(1'b1));
        step("fill_drop", '1, all_cols(16'hDEAD), 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            check("drain.head", 128'(out_bus[BW-1:0]), 128'(k));
            step("drain", '0, '0, 1'b1);
        end
        check("drain.empty", 128'(o_valid), 128'(1'b0));

        // Full FIFO with a simultaneous write and pop keeps occupancy at depth.
        for (int k = 0; k < DEPTH; k++) step("refill", '1, all_cols(BW'(k)), 1'b0);
        step("full_wr_pop", '1, all_cols(BW'(DEPTH)), 1'b1);
        check("full_wr_pop.full", 128'(o_full), 128'(1'b1));
        check("full_wr_pop.head", 128'(out_bus[BW-1:0]), 128'(1));
        for (int k = 0; k < DEPTH; k++) step("drain2", '0, '0, 1'b1);

        // Continuous push/pop across many pointer wraps.
        step("wrap_prime", '1, all_cols(16'd0), 1'b0);
        for (int n = 1; n <= 200; n++) begin
            check("wrap_seq", 128'(out_bus[BW-1:0]), 128'(n - 1));
            step("wrap", '1, all_cols(BW'(n)), 1'b1);
        end
        step("wrap_end", '0, '0, 1'b1);

        // Random traffic with occasional column-sparse writes.
        for (int i = 0; i < 400; i++) begin
            step("rand", COL'($urandom), rand_row(), 1'($urandom_range(0, 2) == 0));
        end

        // Reset with rows buffered: data discarded, new data comes out first.
        for (int k = 0; k < 3; k++) step("pre_rst", '1, rand_row(), 1'b0);
        async_reset("midrst");
        step("post_rst", '1, all_cols(16'h5A5A), 1'b0);
        check("post_rst.row", 128'(out_bus), 128'(all_cols(16'h5A5A)));
        step("post_rst_pop", '0, '0, 1'b1);

`ifdef PSUM_OFIFO_OVF_EN
        for (int k = 0; k < DEPTH; k++) step("ovf_fill", '1, all_cols(BW'(k)), 1'b0);
        check("ovf.clear", 128'(o_overflow), 128'(1'b0));
        step("ovf_drop", COL'(8), all_cols(16'hBEEF), 1'b0);
        check("ovf.set", 128'(o_overflow), 128'(1'b1));
        for (int k = 0; k < 4; k++) step("ovf_pop", '0, '0, 1'b1);
        check("ovf.sticky", 128'(o_overflow), 128'(1'b1));
        async_reset("ovf_rst");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
